// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an external controller and the spi_peripheral block.
// The controller drives sclk/cs_n/copi; the peripheral drives poci and its tristate enable.
interface spi_peripheral_if;
  logic sclk;
  logic cs_n;
  logic copi;
  logic poci;
  logic poci_oe;

  modport master (
    output sclk,
    output cs_n,
    output copi,
    input  poci,
    input  poci_oe
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  copi,
    output poci,
    output poci_oe
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI peripheral (all four modes) with 1..8 byte transactions, oversampling the
// asynchronous SPI pins through two-flop synchronizers in the clk/clk_en domain.
module spi_peripheral #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  sync_rst_n,
  input  logic                  clk_en,
  input  logic [1:0]            spi_mode,
  input  logic [2:0]            byte_sel,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] tx_data,
  spi_peripheral_if.slave       spi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  txn_abort,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  logic [1:0]            sclk_sync_r, cs_sync_r, copi_sync_r;
  logic                  sclk_prev_r, cs_prev_r;
  state_t                state_r, state_nxt_s;
  logic [1:0]            mode_r, mode_nxt_s;
  logic [2:0]            bsel_r, bsel_nxt_s;
  logic [CW-1:0]         cnt_r, cnt_nxt_s;
  logic [DATA_WIDTH-1:0] tx_buf_r, tx_buf_nxt_s;
  logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_nxt_s;
  logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_nxt_s;
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_nxt_s;
  logic                  first_r, first_nxt_s;
  logic                  rx_valid_nxt_s, abort_nxt_s, poci_nxt_s;
  logic                  poci_r, poci_oe_r, rx_valid_r, txn_abort_r, busy_r;

  logic                  sclk_s, cs_s, copi_s;
  logic                  sclk_rise_s, sclk_fall_s, lead_s, trail_s;
  logic                  sample_s, shift_s, cs_fall_s;
  logic [CW-1:0]         n_in_s, n_act_s;
  logic [DATA_WIDTH-1:0] tx_load_s;

  assign sclk_s      = sclk_sync_r[1];
  assign cs_s        = cs_sync_r[1];
  assign copi_s      = copi_sync_r[1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r;
  assign cs_fall_s   = cs_prev_r & ~cs_s;
  // Leading edge is the first transition away from the CPOL idle level.
  assign lead_s      = mode_r[1] ? sclk_fall_s : sclk_rise_s;
  assign trail_s     = mode_r[1] ? sclk_rise_s : sclk_fall_s;
  assign sample_s    = mode_r[0] ? trail_s : lead_s;
  assign shift_s     = mode_r[0] ? lead_s : trail_s;
  assign n_in_s      = CW'((32'(byte_sel) + 32'd1) * 32'd8);
  assign n_act_s     = CW'((32'(bsel_r) + 32'd1) * 32'd8);
  // A write in the same cycle as selection is transmitted immediately.
  assign tx_load_s   = wr_en ? tx_data : tx_buf_r;

  // Pin synchronizers and previous-value flops for edge detection.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      sclk_sync_r <= 2'b00;
      cs_sync_r   <= 2'b11;
      copi_sync_r <= 2'b00;
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else if (clk_en) begin
      sclk_sync_r <= {sclk_sync_r[0], spi.sclk};
      cs_sync_r   <= {cs_sync_r[0], spi.cs_n};
      copi_sync_r <= {copi_sync_r[0], spi.copi};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
    end
  end

  // Next-state, shift datapath and output-pulse decode.
  always_comb begin
    state_nxt_s    = state_r;
    mode_nxt_s     = mode_r;
    bsel_nxt_s     = bsel_r;
    cnt_nxt_s      = cnt_r;
    tx_buf_nxt_s   = tx_buf_r;
    tx_shift_nxt_s = tx_shift_r;
    rx_shift_nxt_s = rx_shift_r;
    rx_data_nxt_s  = rx_data_r;
    first_nxt_s    = first_r;
    rx_valid_nxt_s = 1'b0;
    abort_nxt_s    = 1'b0;
    poci_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_en) begin
          tx_buf_nxt_s = tx_data;
        end else begin
          tx_buf_nxt_s = tx_buf_r;
        end
        if (cs_fall_s) begin
          state_nxt_s    = ST_ACTIVE;
          mode_nxt_s     = spi_mode;
          bsel_nxt_s     = byte_sel;
          cnt_nxt_s      = {CW{1'b0}};
          rx_shift_nxt_s = {DATA_WIDTH{1'b0}};
          tx_shift_nxt_s = tx_load_s << (CW'(DATA_WIDTH) - n_in_s);
          first_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_r == n_act_s) begin
          state_nxt_s    = ST_DONE;
          rx_data_nxt_s  = rx_shift_r;
          rx_valid_nxt_s = 1'b1;
        end else if (cs_s) begin
          state_nxt_s = ST_IDLE;
          abort_nxt_s = 1'b1;
        end else begin
          if (sample_s) begin
            rx_shift_nxt_s = {rx_shift_r[DATA_WIDTH-2:0], copi_s};
            cnt_nxt_s      = cnt_r + CW'(1);
          end else begin
            rx_shift_nxt_s = rx_shift_r;
          end
          // With CPHA=1 the first leading edge only exposes the MSB.
          if (shift_s && mode_r[0] && first_r) begin
            first_nxt_s = 1'b0;
          end else if (shift_s) begin
            tx_shift_nxt_s = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
          end else begin
            tx_shift_nxt_s = tx_shift_r;
          end
        end
      end
      ST_DONE: begin
        if (cs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // cs_sync_r[0] is the synchronized cs_n value being registered this cycle.
    if (!cs_sync_r[0] && (state_nxt_s == ST_ACTIVE) && !(mode_nxt_s[0] && first_nxt_s)) begin
      poci_nxt_s = tx_shift_nxt_s[DATA_WIDTH-1];
    end else begin
      poci_nxt_s = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_r     <= ST_IDLE;
      mode_r      <= 2'b00;
      bsel_r      <= 3'd0;
      cnt_r       <= {CW{1'b0}};
      tx_buf_r    <= {DATA_WIDTH{1'b0}};
      tx_shift_r  <= {DATA_WIDTH{1'b0}};
      rx_shift_r  <= {DATA_WIDTH{1'b0}};
      rx_data_r   <= {DATA_WIDTH{1'b0}};
      first_r     <= 1'b0;
      poci_r      <= 1'b0;
      poci_oe_r   <= 1'b0;
      rx_valid_r  <= 1'b0;
      txn_abort_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (clk_en) begin
      state_r     <= state_nxt_s;
      mode_r      <= mode_nxt_s;
      bsel_r      <= bsel_nxt_s;
      cnt_r       <= cnt_nxt_s;
      tx_buf_r    <= tx_buf_nxt_s;
      tx_shift_r  <= tx_shift_nxt_s;
      rx_shift_r  <= rx_shift_nxt_s;
      rx_data_r   <= rx_data_nxt_s;
      first_r     <= first_nxt_s;
      poci_r      <= poci_nxt_s;
      poci_oe_r   <= ~cs_sync_r[0];
      rx_valid_r  <= rx_valid_nxt_s;
      txn_abort_r <= abort_nxt_s;
      busy_r      <= (state_nxt_s == ST_ACTIVE);
    end
  end

  assign spi.poci    = poci_r;
  assign spi.poci_oe = poci_oe_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign txn_abort   = txn_abort_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a bit-banged SPI controller with
// hand-computed expected words for each mode and corner case.
module tb_spi_peripheral;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          sync_rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic [1:0]    spi_mode = 2'b00;
  logic [2:0]    byte_sel = 3'd0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] tx_data = 64'h0;
  logic [DW-1:0] rx_data;
  logic          rx_valid, txn_abort, busy;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int abort_cnt = 0;
  int v0, a0;
  logic [63:0] miso;
  logic mid_busy, mid_oe;
  logic snap_poci, snap_oe, snap_valid, snap_abort, snap_busy;
  logic [63:0] snap_rx;

  spi_peripheral_if spi_bus ();

  spi_peripheral #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .sync_rst_n(sync_rst_n),
    .clk_en    (clk_en),
    .spi_mode  (spi_mode),
    .byte_sel  (byte_sel),
    .wr_en     (wr_en),
    .tx_data   (tx_data),
    .spi       (spi_bus),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .txn_abort (txn_abort),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) valid_cnt <= valid_cnt + 1;
    if (txn_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hp();
    repeat (8) @(negedge clk);
  endtask

  task automatic load(input logic [63:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    tx_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Controller transaction; inject_at / rst_at select a bit index for a mid-transfer event.
  task automatic xfer(input logic [1:0] mode, input logic [2:0] bsel, input int nclk,
                      input logic [63:0] mosi, input int nbits, input int inject_at,
                      input int rst_at, output logic [63:0] got);
    logic cpol, cpha, b;
    cpol = mode[1];
    cpha = mode[0];
    spi_mode = mode;
    byte_sel = bsel;
    spi_bus.sclk = cpol;
    spi_bus.copi = 1'b0;
    got = 64'h0;
    repeat (4) @(negedge clk);
    spi_bus.cs_n = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      if (i == rst_at) begin
        sync_rst_n = 1'b0;
        @(negedge clk);
        snap_poci  = spi_bus.poci;
        snap_oe    = spi_bus.poci_oe;
        snap_rx    = rx_data;
        snap_valid = rx_valid;
        snap_abort = txn_abort;
        snap_busy  = busy;
        sync_rst_n = 1'b1;
        spi_bus.cs_n = 1'b1;
        spi_bus.sclk = cpol;
        repeat (12) @(negedge clk);
        return;
      end
      if (i == inject_at) begin
        mid_busy = busy;
        mid_oe = spi_bus.poci_oe;
        wr_en = 1'b1;
        tx_data = 64'hFF;
        @(negedge clk);
        wr_en = 1'b0;
      end
      b = (i < nbits) ? mosi[nbits-1-i] : 1'b0;
      if (!cpha) begin
        spi_bus.copi = b;
        hp();
        got = {got[62:0], spi_bus.poci};
        spi_bus.sclk = ~cpol;
        hp();
        spi_bus.sclk = cpol;
      end else begin
        hp();
        spi_bus.sclk = ~cpol;
        spi_bus.copi = b;
        hp();
        got = {got[62:0], spi_bus.poci};
        spi_bus.sclk = cpol;
      end
    end
    hp();
    spi_bus.cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    spi_bus.sclk = 1'b0;
    spi_bus.cs_n = 1'b1;
    spi_bus.copi = 1'b0;
    sync_rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_poci", {63'h0, spi_bus.poci}, 64'h0);
    check("rst_poci_oe", {63'h0, spi_bus.poci_oe}, 64'h0);
    check("rst_rx_data", rx_data, 64'h0);
    check("rst_rx_valid", {63'h0, rx_valid}, 64'h0);
    check("rst_txn_abort", {63'h0, txn_abort}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    sync_rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0, one byte
    load(64'hA5);
    v0 = valid_cnt; a0 = abort_cnt;
    xfer(2'b00, 3'd0, 8, 64'h3C, 8, -1, -1, miso);
    check("m0_poci", {56'h0, miso[7:0]}, 64'hA5);
    check("m0_rx_data", rx_data, 64'h3C);
    check("m0_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    check("m0_abort_pulses", 64'(abort_cnt - a0), 64'd0);

    // Mode 3, eight bytes
    load(64'h0123456789ABCDEF);
    v0 = valid_cnt;
    xfer(2'b11, 3'd7, 64, 64'hFEDCBA9876543210, 64, -1, -1, miso);
    check("m3_poci", miso, 64'h0123456789ABCDEF);
    check("m3_rx_data", rx_data, 64'hFEDCBA9876543210);
    check("m3_valid_pulses", 64'(valid_cnt - v0), 64'd1);

    // Mode 1, two bytes, deselected after 9 bits
    load(64'hBEEF);
    v0 = valid_cnt; a0 = abort_cnt;
    xfer(2'b01, 3'd1, 9, 64'h155, 9, -1, -1, miso);
    check("abort_pulses", 64'(abort_cnt - a0), 64'd1);
    check("abort_valid_pulses", 64'(valid_cnt - v0), 64'd0);
    check("abort_rx_data_kept", rx_data, 64'hFEDCBA9876543210);
    check("abort_busy", {63'h0, busy}, 64'h0);

    // Mode 2, one byte, 12 clocks
    load(64'h5A);
    v0 = valid_cnt;
    xfer(2'b10, 3'd0, 12, 64'hC3A, 12, -1, -1, miso);
    check("extra_rx_data", rx_data, 64'hC3);
    check("extra_poci", {52'h0, miso[11:0]}, 64'h5A0);
    check("extra_valid_pulses", 64'(valid_cnt - v0), 64'd1);

    // wr_en while busy is ignored
    load(64'h96);
    xfer(2'b00, 3'd0, 8, 64'h69, 8, 2, -1, miso);
    check("busy_mid", {63'h0, mid_busy}, 64'h1);
    check("poci_oe_mid", {63'h0, mid_oe}, 64'h1);
    check("busy_wr_poci", {56'h0, miso[7:0]}, 64'h96);
    check("busy_wr_rx_data", rx_data, 64'h69);
    xfer(2'b00, 3'd0, 8, 64'h0F, 8, -1, -1, miso);
    check("busy_wr_buf_kept", {56'h0, miso[7:0]}, 64'h96);

    // Reset in the middle of a transfer
    v0 = valid_cnt; a0 = abort_cnt;
    xfer(2'b00, 3'd0, 8, 64'hA5, 8, -1, 3, miso);
    check("mid_rst_poci", {63'h0, snap_poci}, 64'h0);
    check("mid_rst_poci_oe", {63'h0, snap_oe}, 64'h0);
    check("mid_rst_rx_data", snap_rx, 64'h0);
    check("mid_rst_rx_valid", {63'h0, snap_valid}, 64'h0);
    check("mid_rst_txn_abort", {63'h0, snap_abort}, 64'h0);
    check("mid_rst_busy", {63'h0, snap_busy}, 64'h0);
    check("mid_rst_valid_pulses", 64'(valid_cnt - v0), 64'd0);
    check("mid_rst_abort_pulses", 64'(abort_cnt - a0), 64'd0);
    check("mid_rst_busy_after", {63'h0, busy}, 64'h0);

    // Recovery: transmit buffer was cleared by reset
    v0 = valid_cnt;
    xfer(2'b00, 3'd0, 8, 64'h81, 8, -1, -1, miso);
    check("post_rst_poci", {56'h0, miso[7:0]}, 64'h0);
    check("post_rst_rx_data", rx_data, 64'h81);
    check("post_rst_valid_pulses", 64'(valid_cnt - v0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, maximum transaction width in bits (multiple of 8).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port sync_rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port clk_en  input  1  clock enable; all state (synchronizers included) advances only when 1.
REQ-005 SHALL have port spi_mode  input  2  {CPOL,CPHA}; sampled only in IDLE.
REQ-006 SHALL have port byte_sel  input  3  transaction length = byte_sel+1 bytes; sampled only in IDLE.
REQ-007 SHALL have port wr_en  input  1  load tx_data into transmit buffer.
REQ-008 SHALL have port tx_data  input  DATA_WIDTH  parallel transmit data.
REQ-009 SHALL have port sclk  input  1  serial clock from controller, asynchronous.
REQ-010 SHALL have port cs_n  input  1  peripheral select, active-low, asynchronous.
REQ-011 SHALL have port copi  input  1  controller out, peripheral in, asynchronous.
REQ-012 SHALL have port poci  output  1  peripheral out, controller in.
REQ-013 SHALL have port poci_oe  output  1  1 while selected; external tristate enable.
REQ-014 SHALL have port rx_data  output  DATA_WIDTH  last completed received word, right-aligned.
REQ-015 SHALL have port rx_valid  output  1  one clk_en-cycle pulse on completion.
REQ-016 SHALL have port txn_abort  output  1  one clk_en-cycle pulse on early deselect.
REQ-017 SHALL have port busy  output  1  1 in ACTIVE state.

Function
REQ-018 SHALL pass sclk, cs_n, copi through two-flop synchronizers; edges detected on synchronized values; sclk rate SHALL be at most clk_en rate / 4.
REQ-019 SHALL implement FSM IDLE -> ACTIVE on synchronized cs_n falling edge; ACTIVE -> DONE when bit count reaches N = 8*(byte_sel+1); ACTIVE -> IDLE on cs_n rise before N; DONE -> IDLE when cs_n high.
REQ-020 SHALL latch spi_mode and byte_sel at IDLE->ACTIVE and hold them through the transaction.
REQ-021 SHALL sample copi on leading sclk edge when CPHA=0, trailing edge when CPHA=1; leading = rising if CPOL=0, falling if CPOL=1.
REQ-022 SHALL shift poci on the edge opposite the sample edge; CPHA=0: bit N-1 valid on poci from the ACTIVE entry cycle; CPHA=1: bit N-1 driven at first leading edge.
REQ-023 SHALL transmit tx buffer bits [N-1:0] MSB first; SHALL receive MSB first into LSB-shifting register.
REQ-024 SHALL use a bit counter of $clog2(DATA_WIDTH)+1 bits, cleared at ACTIVE entry, incremented per sample edge.
REQ-025 SHALL, one clk_en cycle after the N-th sample, update rx_data with received bits in [N-1:0], zeros above, and pulse rx_valid.
REQ-026 SHALL ignore sclk edges in DONE and IDLE; extra bits are discarded; poci holds 0 in DONE.
REQ-027 SHALL, on cs_n rise in ACTIVE, pulse txn_abort, leave rx_data unchanged, and not pulse rx_valid.
REQ-028 SHALL accept wr_en only in IDLE; wr_en in ACTIVE or DONE is ignored; wr_en and cs_n fall in same cycle: load takes effect first.
REQ-029 SHALL drive poci=0 and poci_oe=0 whenever synchronized cs_n is high.

Reset
REQ-030 SHALL, with sync_rst_n=0 at a clk edge, regardless of clk_en, enter IDLE, clear tx buffer, rx shift register, rx_data, counter and synchronizers (cs_n sync to 1).
REQ-031 SHALL drive outputs after reset: poci=0, poci_oe=0, rx_data=0, rx_valid=0, txn_abort=0, busy=0.
REQ-032 SHALL, on reset mid-transaction, abandon it without rx_valid or txn_abort pulse.

Verification
REQ-033 Mode 0, byte_sel=0, tx_data=0xA5, controller sends 0x3C -> poci carries 1010_0101, rx_data=0x3C, one rx_valid pulse.
REQ-034 Mode 3, byte_sel=7, tx_data=0x0123456789ABCDEF, copi sends 0xFEDCBA9876543210 -> poci MSB-first match, rx_data=0xFEDCBA9876543210.
REQ-035 Mode 1, byte_sel=1, cs_n raised after 9 bits -> txn_abort pulse, rx_valid=0, rx_data keeps prior value.
REQ-036 Mode 2, byte_sel=0, 12 sclk cycles sent -> rx_data equals first 8 bits only; extra 4 ignored.
REQ-037 wr_en with tx_data=0xFF while busy -> buffer unchanged, transmitted byte is prior value.
REQ-038 sync_rst_n low mid-transaction for one cycle -> all outputs at reset values, busy=0, no pulses.
